// File: rtl/sdrc_port_arbiter_pkg.sv
// Shared types and widths for the DDR burst-command port arbiter.
package sdrc_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_ST_IDLE    = 2'd0,
      ARB_ST_WAIT_LO = 2'd1,
      ARB_ST_WAIT_HI = 2'd2
   } arb_st_e;

   localparam int EXT_BUF_MEM_ADDR_WIDTH = 24;
   localparam int SDRC_LEN_W             = 5;

endpackage

// File: rtl/sdrc_port_arbiter_arb_id_fifo.sv
// Synchronous FIFO of requester IDs, one entry per outstanding read burst, in issue order.
module arb_id_fifo
   import sdrc_port_arbiter_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = 2
) (
   input  logic                              phy_clk,
   input  logic                              rst_n,
   input  logic                              push,
   input  logic [W-1:0]                      push_id,
   input  logic                              pop,
   output logic [W-1:0]                      head_id,
   output logic                              full,
   output logic                              empty,
   output logic [((DEPTH>1)?$clog2(DEPTH):1):0] count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW:0]   count_q, count_d;
   logic          do_push, do_pop;

   assign full    = (count_q == (PW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign head_id = mem_q[rd_ptr_q];

   // A push while full is only honoured if a pop frees the slot in the same cycle.
   assign do_push = push & (~full | pop);
   assign do_pop  = pop & ~empty;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_id;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge phy_clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/sdrc_port_arbiter.sv
// Round-robin arbiter (urgent override) sharing the DDR burst-command port; steers read beats to
// the requester that owns the oldest outstanding read.
module sdrc_port_arbiter
   import sdrc_port_arbiter_pkg::*;
#(
   parameter int NUM_REQ       = 3,
   parameter int AW            = EXT_BUF_MEM_ADDR_WIDTH,
   parameter int RD_FIFO_DEPTH = 4
) (
   input  logic                             phy_clk,
   input  logic                             rst_n,
   input  logic [NUM_REQ-1:0]               req,
   input  logic [NUM_REQ-1:0]               req_wr,
   input  logic [SDRC_LEN_W*NUM_REQ-1:0]    req_len_minus1,
   input  logic [AW*NUM_REQ-1:0]            req_addr,
   input  logic [NUM_REQ-1:0]               urgent,
   output logic [NUM_REQ-1:0]               gnt,
   output logic                             sdrc_act,
   output logic [AW+SDRC_LEN_W:0]           sdrc_cmd,
   input  logic                             sdrc_ready,
   input  logic                             sdrc_read_done,
   input  logic                             sdrc_rvalid,
   output logic [NUM_REQ-1:0]               rd_valid,
   output logic [NUM_REQ-1:0]               rd_last,
   output logic                             busy,
   output logic                             err_underflow
);

   localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = ((RD_FIFO_DEPTH > 1) ? $clog2(RD_FIFO_DEPTH) : 1) + 1;

   // First set bit of mask, scanning upward from ptr with wrap at NUM_REQ-1.
   function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] mask,
                                                input logic [ID_W-1:0]    ptr);
      logic [ID_W-1:0] idx;
      logic [ID_W-1:0] pick;
      logic            found;
      pick  = '0;
      found = 1'b0;
      idx   = ptr;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!found && mask[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
         idx = (idx == ID_W'(NUM_REQ-1)) ? '0 : idx + 1'b1;
      end
      return pick;
   endfunction

   arb_st_e                 state_q, state_d;
   logic [NUM_REQ-1:0]      gnt_q, gnt_d;
   logic                    act_q, act_d;
   logic [AW+SDRC_LEN_W:0]  cmd_q, cmd_d;
   logic [ID_W-1:0]         rr_ptr_q, rr_ptr_d;
   logic                    err_q, err_d;

   logic [NUM_REQ-1:0]      eligible, elig_urg;
   logic [ID_W-1:0]         win;
   logic                    push, pop;
   logic [ID_W-1:0]         head_id;
   logic                    fifo_full, fifo_empty;
   logic [CNT_W-1:0]        fifo_count;

   arb_id_fifo #(
      .DEPTH (RD_FIFO_DEPTH),
      .W     (ID_W)
   ) u_id_fifo (
      .phy_clk (phy_clk),
      .rst_n   (rst_n),
      .push    (push),
      .push_id (win),
      .pop     (pop),
      .head_id (head_id),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   // Reads cannot be issued without a free ID slot; writes never need one.
   assign eligible = req & ~(~req_wr & {NUM_REQ{fifo_full}});
   assign elig_urg = eligible & urgent;
   assign win      = rr_pick((|elig_urg) ? elig_urg : eligible, rr_ptr_q);

   always_comb begin
      state_d  = state_q;
      gnt_d    = '0;
      act_d    = 1'b0;
      cmd_d    = cmd_q;
      rr_ptr_d = rr_ptr_q;
      push     = 1'b0;
      case (state_q)
         ARB_ST_IDLE: begin
            if (sdrc_ready && |eligible) begin
               state_d  = ARB_ST_WAIT_LO;
               act_d    = 1'b1;
               gnt_d    = NUM_REQ'(1) << win;
               cmd_d    = {req_wr[win],
                           req_len_minus1[SDRC_LEN_W*int'(win) +: SDRC_LEN_W],
                           req_addr[AW*int'(win) +: AW]};
               push     = ~req_wr[win];
               rr_ptr_d = (win == ID_W'(NUM_REQ-1)) ? '0 : win + 1'b1;
            end
         end
         // sdrc_ready is still stale in the act cycle, so it is ignored here.
         ARB_ST_WAIT_LO: state_d = ARB_ST_WAIT_HI;
         ARB_ST_WAIT_HI: if (sdrc_ready) state_d = ARB_ST_IDLE;
         default:        state_d = ARB_ST_IDLE;
      endcase
   end

   assign pop   = sdrc_read_done & ~fifo_empty;
   assign err_d = err_q | (fifo_empty & (sdrc_rvalid | sdrc_read_done));

   always_ff @(posedge phy_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ARB_ST_IDLE;
         gnt_q    <= '0;
         act_q    <= 1'b0;
         cmd_q    <= '0;
         rr_ptr_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         act_q    <= act_d;
         cmd_q    <= cmd_d;
         rr_ptr_q <= rr_ptr_d;
         err_q    <= err_d;
      end
   end

   assign gnt           = gnt_q;
   assign sdrc_act      = act_q;
   assign sdrc_cmd      = cmd_q;
   assign err_underflow = err_q;
   assign busy          = (state_q != ARB_ST_IDLE) | (fifo_count != '0);
   assign rd_valid      = fifo_empty ? '0 : (NUM_REQ'(sdrc_rvalid) << head_id);
   assign rd_last       = fifo_empty ? '0 : (NUM_REQ'(sdrc_read_done) << head_id);

endmodule

// File: tb/tb_sdrc_port_arbiter.sv
// Scoreboard bench for sdrc_port_arbiter: directed sequences push expected grants/read beats,
// a negedge monitor pops and compares whenever the DUT strobes act or a steered read output.
module tb_sdrc_port_arbiter;

   localparam int NUM_REQ    = 3;
   localparam int AW         = 16;
   localparam int DEPTH      = 4;
   localparam int CTRL_BUSY  = 4;

   logic                  phy_clk;
   logic                  rst_n;
   logic [NUM_REQ-1:0]    req, req_wr, urgent;
   logic [5*NUM_REQ-1:0]  req_len_minus1;
   logic [AW*NUM_REQ-1:0] req_addr;
   logic [NUM_REQ-1:0]    gnt, rd_valid, rd_last;
   logic                  sdrc_act, sdrc_ready, sdrc_read_done, sdrc_rvalid;
   logic [AW+5:0]         sdrc_cmd;
   logic                  busy, err_underflow;

   sdrc_port_arbiter #(
      .NUM_REQ       (NUM_REQ),
      .AW            (AW),
      .RD_FIFO_DEPTH (DEPTH)
   ) dut (
      .phy_clk        (phy_clk),
      .rst_n          (rst_n),
      .req            (req),
      .req_wr         (req_wr),
      .req_len_minus1 (req_len_minus1),
      .req_addr       (req_addr),
      .urgent         (urgent),
      .gnt            (gnt),
      .sdrc_act       (sdrc_act),
      .sdrc_cmd       (sdrc_cmd),
      .sdrc_ready     (sdrc_ready),
      .sdrc_read_done (sdrc_read_done),
      .sdrc_rvalid    (sdrc_rvalid),
      .rd_valid       (rd_valid),
      .rd_last        (rd_last),
      .busy           (busy),
      .err_underflow  (err_underflow)
   );

   initial phy_clk = 1'b0;
   always #5 phy_clk = ~phy_clk;

   typedef struct {
      logic [NUM_REQ-1:0] gnt;
      logic [AW+5:0]      cmd;
   } cmd_exp_t;

   typedef struct {
      logic [NUM_REQ-1:0] v;
      logic [NUM_REQ-1:0] l;
   } rd_exp_t;

   cmd_exp_t   cmd_sb[$];
   rd_exp_t    rd_sb[$];
   cmd_exp_t   mce;
   rd_exp_t    mre;
   int         n_chk = 0;
   int         n_fail = 0;
   logic [4:0]    lens  [NUM_REQ];
   logic [AW-1:0] addrs [NUM_REQ];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic exp_cmd(input int i, input logic wr);
      cmd_exp_t e;
      e.gnt = NUM_REQ'(1) << i;
      e.cmd = {wr, lens[i], addrs[i]};
      cmd_sb.push_back(e);
   endtask

   task automatic tick();
      @(posedge phy_clk);
      #1;
   endtask

   task automatic wait_act(input string name);
      int t;
      t = 0;
      @(negedge phy_clk);
      while (sdrc_act !== 1'b1 && t < 60) begin
         @(negedge phy_clk);
         t++;
      end
      if (sdrc_act !== 1'b1) check({name, "_act_timeout"}, 64'd0, 64'd1);
   endtask

   task automatic wait_idle(input string name);
      int t;
      t = 0;
      @(negedge phy_clk);
      while (busy !== 1'b0 && t < 100) begin
         @(negedge phy_clk);
         t++;
      end
      check({name, "_idle"}, 64'(busy), 64'd0);
   endtask

   task automatic return_burst(input int owner, input int beats);
      rd_exp_t e;
      tick();
      for (int b = 0; b < beats; b++) begin
         e.v = NUM_REQ'(1) << owner;
         e.l = (b == beats-1) ? (NUM_REQ'(1) << owner) : '0;
         rd_sb.push_back(e);
         sdrc_rvalid    = 1'b1;
         sdrc_read_done = (b == beats-1);
         tick();
      end
      sdrc_rvalid    = 1'b0;
      sdrc_read_done = 1'b0;
   endtask

   // Burst controller model: ready drops after each act and recovers CTRL_BUSY cycles later.
   initial begin
      sdrc_ready = 1'b1;
      forever begin
         @(negedge phy_clk);
         if (sdrc_act === 1'b1) begin
            sdrc_ready = 1'b0;
            repeat (CTRL_BUSY) @(negedge phy_clk);
            sdrc_ready = 1'b1;
         end
      end
   end

   always @(negedge phy_clk) begin
      if (rst_n === 1'b1) begin
         if (sdrc_act === 1'b1) begin
            if (cmd_sb.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL unexpected_act: gnt=%0b cmd=%0h with nothing expected", gnt, sdrc_cmd);
            end else begin
               mce = cmd_sb.pop_front();
               check("gnt", 64'(gnt), 64'(mce.gnt));
               check("cmd", 64'(sdrc_cmd), 64'(mce.cmd));
            end
         end else if (gnt !== '0) begin
            n_chk++; n_fail++;
            $display("FAIL gnt_without_act: gnt=%0b expected 0", gnt);
         end
         if ((rd_valid | rd_last) !== '0) begin
            if (rd_sb.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL unexpected_rd: rd_valid=%0b rd_last=%0b expected 0", rd_valid, rd_last);
            end else begin
               mre = rd_sb.pop_front();
               check("rd_valid", 64'(rd_valid), 64'(mre.v));
               check("rd_last", 64'(rd_last), 64'(mre.l));
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      lens[0] = 5'd3;  addrs[0] = 16'h1000;
      lens[1] = 5'd7;  addrs[1] = 16'h2340;
      lens[2] = 5'd15; addrs[2] = 16'hBEE0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_len_minus1[5*i +: 5] = lens[i];
         req_addr[AW*i +: AW]     = addrs[i];
      end
      rst_n = 1'b0; req = '0; req_wr = '0; urgent = '0;
      sdrc_rvalid = 1'b0; sdrc_read_done = 1'b0;
      #12;
      check("rst_gnt",  64'(gnt), 64'd0);
      check("rst_act",  64'(sdrc_act), 64'd0);
      check("rst_cmd",  64'(sdrc_cmd), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_err",  64'(err_underflow), 64'd0);
      @(negedge phy_clk);
      rst_n = 1'b1;
      tick();

      // 1: all three read, held; 0,1,2,0 then FIFO full masks further reads
      req_wr = 3'b000; req = 3'b111;
      exp_cmd(0, 0); exp_cmd(1, 0); exp_cmd(2, 0); exp_cmd(0, 0);
      repeat (4) wait_act("t1");
      repeat (12) @(negedge phy_clk);
      check("t1_held_busy", 64'(busy), 64'd1);
      req = 3'b000;
      return_burst(0, 1); return_burst(1, 2); return_burst(2, 1); return_burst(0, 3);
      wait_idle("t1");

      // 2: writes from 0/1, urgent 2 jumps in, RR then resumes at 0 (rr_ptr starts at 1)
      req_wr = 3'b111; req = 3'b011;
      exp_cmd(1, 1);
      wait_act("t2a");
      req = 3'b111; urgent = 3'b100;
      exp_cmd(2, 1);
      wait_act("t2b");
      req = 3'b011; urgent = 3'b000;
      exp_cmd(0, 1); exp_cmd(1, 1);
      wait_act("t2c");
      wait_act("t2d");
      req = 3'b000;
      wait_idle("t2");

      // 3: four reads from 1 fill the FIFO; a write from 0 still passes; 5th read after a pop
      req_wr = 3'b000; req = 3'b010;
      repeat (4) exp_cmd(1, 0);
      repeat (4) wait_act("t3");
      req_wr = 3'b001; req = 3'b011;
      exp_cmd(0, 1);
      wait_act("t3w");
      req = 3'b010;
      repeat (12) @(negedge phy_clk);
      check("t3_held_busy", 64'(busy), 64'd1);
      exp_cmd(1, 0);
      return_burst(1, 2);
      wait_act("t3_5th");
      req = 3'b000;
      repeat (4) return_burst(1, 1);
      wait_idle("t3");

      // 4: reads granted 2,0,1; returns of 4/2/8 beats steered in issue order
      req_wr = 3'b000; req = 3'b111;
      exp_cmd(2, 0); exp_cmd(0, 0); exp_cmd(1, 0);
      repeat (3) begin
         wait_act("t4");
         req = req & ~gnt;
      end
      return_burst(2, 4); return_burst(0, 2); return_burst(1, 8);
      wait_idle("t4");

      // 5: pop of read 0 coincides with push of read 2
      req = 3'b001;
      exp_cmd(0, 0);
      wait_act("t5a");
      req = 3'b000;
      repeat (10) @(negedge phy_clk);
      tick();
      req = 3'b100;
      sdrc_rvalid = 1'b1; sdrc_read_done = 1'b1;
      rd_sb.push_back('{v: 3'b001, l: 3'b001});
      exp_cmd(2, 0);
      tick();
      sdrc_rvalid = 1'b0; sdrc_read_done = 1'b0;
      wait_act("t5b");
      req = 3'b000;
      repeat (10) @(negedge phy_clk);
      check("t5_busy_one", 64'(busy), 64'd1);
      return_burst(2, 3);
      wait_idle("t5");

      // 6: async reset in WAIT_HI with two reads outstanding, then a stray read_done
      req = 3'b011;
      exp_cmd(0, 0); exp_cmd(1, 0);
      wait_act("t6a");
      req = 3'b010;
      wait_act("t6b");
      req = 3'b000;
      repeat (2) @(negedge phy_clk);
      check("t6_pre_cmd",  64'(sdrc_cmd), 64'({1'b0, lens[1], addrs[1]}));
      check("t6_pre_busy", 64'(busy), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_rst_cmd",  64'(sdrc_cmd), 64'd0);
      check("t6_rst_busy", 64'(busy), 64'd0);
      check("t6_rst_gnt",  64'(gnt), 64'd0);
      check("t6_rst_act",  64'(sdrc_act), 64'd0);
      repeat (2) @(negedge phy_clk);
      rst_n = 1'b1;
      repeat (6) @(negedge phy_clk);
      tick();
      sdrc_rvalid = 1'b1; sdrc_read_done = 1'b1;
      tick();
      sdrc_rvalid = 1'b0; sdrc_read_done = 1'b0;
      @(negedge phy_clk);
      check("t6_err_set", 64'(err_underflow), 64'd1);
      repeat (4) tick();
      check("t6_err_sticky", 64'(err_underflow), 64'd1);
      check("t6_busy_after", 64'(busy), 64'd0);

      check("cmd_sb_empty", 64'(cmd_sb.size()), 64'd0);
      check("rd_sb_empty",  64'(rd_sb.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
